// File: rtl/spike_packet_encoder.sv
// Scans a captured per-neuron spike vector and emits one {dx, dy, idx} packet per firing neuron.
// Optional per-frame accepted-packet counter: define SPIKE_COUNT_EN to add spike_count_o.
module spike_packet_encoder #(
    parameter int NUM_NEURONS = 256,
    parameter int IDX_W       = 8,
    parameter int DXY_W       = 9
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_NEURONS-1:0]     spikes_i,
    input  logic                       spikes_valid_i,
    output logic                       spikes_ready_o,
    input  logic [DXY_W-1:0]           dest_dx_i,
    input  logic [DXY_W-1:0]           dest_dy_i,
    output logic [2*DXY_W+IDX_W-1:0]   pkt_o,
    output logic                       pkt_valid_o,
    input  logic                       pkt_ready_i,
    output logic                       busy_o,
    output logic                       done_o,
`ifdef SPIKE_COUNT_EN
    output logic [IDX_W:0]             spike_count_o,
`endif
    output logic [1:0]                 dbg_state_o
);

    localparam int PKT_W = 2*DXY_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_NEURONS-1:0] vec_q, vec_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DXY_W-1:0]       dx_q, dx_d;
    logic [DXY_W-1:0]       dy_q, dy_d;
    logic [PKT_W-1:0]       pkt_q, pkt_d;
    logic                   pkt_valid_q, pkt_valid_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;
    logic                   load;
    logic                   accept;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; the producer holds its payload stable while valid is high and ready is low.
    assign load   = (state_q == ST_IDLE) && spikes_valid_i;
    assign accept = (state_q == ST_SEND) && pkt_ready_i;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        pkt_d   = pkt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (spikes_valid_i) begin
                    vec_d   = spikes_i;
                    dx_d    = dest_dx_i;
                    dy_d    = dest_dy_i;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (vec_q[idx_q]) begin
                    pkt_d   = {dx_q, dy_q, idx_q};
                    state_d = ST_SEND;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (pkt_ready_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs are registered from the next state so they line up with state_q.
        pkt_valid_d = (state_d == ST_SEND);
        done_d      = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        ready_d     = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            idx_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            pkt_q       <= '0;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            idx_q       <= idx_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            pkt_q       <= pkt_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

`ifdef SPIKE_COUNT_EN
    logic [IDX_W:0] cnt_q, cnt_d;

    // Wide enough to hold NUM_NEURONS when every neuron fires.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign spike_count_o = cnt_q;
`else
    logic unused_accept;
    assign unused_accept = accept ^ load;
`endif

    assign pkt_o          = pkt_q;
    assign pkt_valid_o    = pkt_valid_q;
    assign done_o         = done_q;
    assign busy_o         = busy_q;
    assign spikes_ready_o = ready_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_spike_packet_encoder.sv
// Bench for spike_packet_encoder: table of frames, scoreboard of expected packets, corner sequences.
module tb_spike_packet_encoder;

    localparam int N     = 256;
    localparam int PKT_W = 26;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [N-1:0]     spikes_i = '0;
    logic             spikes_valid_i = 1'b0;
    logic             spikes_ready_o;
    logic [8:0]       dest_dx_i = '0;
    logic [8:0]       dest_dy_i = '0;
    logic [PKT_W-1:0] pkt_o;
    logic             pkt_valid_o;
    logic             pkt_ready_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic [1:0]       dbg_state_o;
`ifdef SPIKE_COUNT_EN
    logic [8:0]       spike_count_o;
`endif

    spike_packet_encoder dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .spikes_i       (spikes_i),
        .spikes_valid_i (spikes_valid_i),
        .spikes_ready_o (spikes_ready_o),
        .dest_dx_i      (dest_dx_i),
        .dest_dy_i      (dest_dy_i),
        .pkt_o          (pkt_o),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_ready_i    (pkt_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
`ifdef SPIKE_COUNT_EN
        .spike_count_o  (spike_count_o),
`endif
        .dbg_state_o    (dbg_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int sent_cnt = 0;
    logic [PKT_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: sampled on the falling edge, a valid&ready pair here completes on the next rise
    logic             prev_stall = 1'b0;
    logic             prev_acc   = 1'b0;
    logic [PKT_W-1:0] prev_pkt   = '0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", pkt_valid_o, 1);
                check("stall_pkt_held", pkt_o, prev_pkt);
            end
            if (prev_acc) check("no_back_to_back", pkt_valid_o, 0);
            if (pkt_valid_o && pkt_ready_i) begin
                sent_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt", pkt_o, '1);
                end else begin
                    check("pkt_data", pkt_o, exp_q.pop_front());
                end
            end
            prev_stall = pkt_valid_o && !pkt_ready_i;
            prev_acc   = pkt_valid_o && pkt_ready_i;
            prev_pkt   = pkt_o;
        end
    end

    // driver tasks
    task automatic push_expected(input logic [N-1:0] vec, input logic [8:0] dx, input logic [8:0] dy);
        for (int i = 0; i < N; i++) begin
            if (vec[i]) exp_q.push_back({dx, dy, 8'(i)});
        end
    endtask

    // Returns 2 time units into cycle 1 (the load edge is cycle 0).
    task automatic load_vec(input logic [N-1:0] vec, input logic [8:0] dx, input logic [8:0] dy);
        @(negedge clk_i);
        check("load_ready", spikes_ready_o, 1);
        push_expected(vec, dx, dy);
        @(posedge clk_i); #2;
        spikes_i       = vec;
        dest_dx_i      = dx;
        dest_dy_i      = dy;
        spikes_valid_i = 1'b1;
        @(posedge clk_i); #2;
        spikes_valid_i = 1'b0;
        spikes_i       = ~vec;
        dest_dx_i      = ~dx;
        dest_dy_i      = ~dy;
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for 10 valid cycles, then high
    task automatic wait_frame(input int mode, output int done_cyc, output int busy_cyc);
        int wait_cnt;
        wait_cnt = 0;
        done_cyc = -1;
        busy_cyc = 0;
        for (int n = 1; n < 4000; n++) begin
            case (mode)
                0: pkt_ready_i = 1'b1;
                1: pkt_ready_i = 1'($urandom_range(0, 1));
                default: begin
                    if (pkt_valid_o) begin
                        wait_cnt++;
                        pkt_ready_i = (wait_cnt > 10);
                    end else begin
                        wait_cnt    = 0;
                        pkt_ready_i = 1'b0;
                    end
                end
            endcase
            @(negedge clk_i);
            if (busy_o) busy_cyc++;
            if (done_o) begin
                done_cyc = n;
                break;
            end
            @(posedge clk_i); #2;
        end
        pkt_ready_i = 1'b0;
        check("frame_finished", done_cyc > 0, 1);
    endtask

    typedef struct {
        logic [N-1:0] vec;
        logic [8:0]   dx;
        logic [8:0]   dy;
        int           mode;
        int           exp_pkts;
        int           exp_done;
    } frame_t;

    frame_t tbl[6];

    initial begin
        int d, b, d1, d2;
        logic seen;
        logic [N-1:0] va, vb;

        tbl[0] = '{vec: '0, dx: 9'h001, dy: 9'h000, mode: 0, exp_pkts: 0, exp_done: 257};
        tbl[1] = '{vec: '0, dx: 9'h1FF, dy: 9'h002, mode: 0, exp_pkts: 3, exp_done: 260};
        tbl[1].vec[0] = 1'b1; tbl[1].vec[5] = 1'b1; tbl[1].vec[255] = 1'b1;
        tbl[2] = '{vec: '0, dx: 9'h003, dy: 9'h1F0, mode: 2, exp_pkts: 1, exp_done: 268};
        tbl[2].vec[7] = 1'b1;
        tbl[3] = '{vec: '1, dx: 9'h0AA, dy: 9'h155, mode: 1, exp_pkts: 256, exp_done: 0};
        tbl[4] = '{vec: '0, dx: 9'h17F, dy: 9'h081, mode: 0, exp_pkts: 0, exp_done: 0};
        for (int i = 0; i < N; i++) tbl[4].vec[i] = 1'($urandom_range(0, 1));
        tbl[4].exp_pkts = $countones(tbl[4].vec);
        tbl[4].exp_done = 257 + tbl[4].exp_pkts;
        tbl[5] = '{vec: '0, dx: 9'h100, dy: 9'h0FF, mode: 2, exp_pkts: 1, exp_done: 268};
        tbl[5].vec[255] = 1'b1;

        // reset state
        #12;
        check("rst_ready", spikes_ready_o, 1);
        check("rst_valid", pkt_valid_o, 0);
        check("rst_pkt", pkt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
`ifdef SPIKE_COUNT_EN
        check("rst_count", spike_count_o, 0);
`endif
        @(posedge clk_i); #2;
        rst_ni = 1'b1;

        for (int t = 0; t < 6; t++) begin
            sent_cnt = 0;
            load_vec(tbl[t].vec, tbl[t].dx, tbl[t].dy);
            wait_frame(tbl[t].mode, d, b);
            if (tbl[t].exp_done > 0) check($sformatf("t%0d_done_cycle", t), d, tbl[t].exp_done);
            check($sformatf("t%0d_busy_cycles", t), b, d);
            check($sformatf("t%0d_pkts_left", t), exp_q.size(), 0);
            check($sformatf("t%0d_sent", t), sent_cnt, tbl[t].exp_pkts);
            @(negedge clk_i);
            check($sformatf("t%0d_done_pulse", t), done_o, 0);
            check($sformatf("t%0d_idle_ready", t), spikes_ready_o, 1);
            check($sformatf("t%0d_idle_busy", t), busy_o, 0);
`ifdef SPIKE_COUNT_EN
            check($sformatf("t%0d_count", t), spike_count_o, tbl[t].exp_pkts);
`endif
        end

        // new vector offered during SEND and held through DONE
        va = '0; va[3] = 1'b1; va[200] = 1'b1;
        vb = '0; vb[9] = 1'b1;
        load_vec(va, 9'd5, 9'd6);
        pkt_ready_i = 1'b1;
        seen = 1'b0;
        d1 = -1;
        for (int n = 1; n < 1000; n++) begin
            if (!seen && pkt_valid_o) begin
                seen = 1'b1;
                spikes_i = vb; dest_dx_i = 9'd7; dest_dy_i = 9'd8; spikes_valid_i = 1'b1;
                push_expected(vb, 9'd7, 9'd8);
            end
            @(negedge clk_i);
            if (d1 < 0 && done_o) begin
                d1 = n;
            end else if (d1 >= 0) begin
                check("busyload_idle_ready", spikes_ready_o, 1);
                break;
            end
            @(posedge clk_i); #2;
        end
        check("busyload_first_done", d1, 259);
        @(posedge clk_i); #2;
        spikes_valid_i = 1'b0;
        spikes_i = '0;
        wait_frame(0, d2, b);
        check("busyload_second_done", d2, 258);
        check("busyload_pkts_left", exp_q.size(), 0);

        // reset while a packet is stalled
        @(negedge clk_i);
        va = '0; va[100] = 1'b1;
        load_vec(va, 9'h012, 9'h034);
        pkt_ready_i = 1'b0;
        for (int n = 0; n < 400 && !pkt_valid_o; n++) begin
            @(posedge clk_i); #2;
        end
        check("rst_mid_reached_send", pkt_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_valid", pkt_valid_o, 0);
        check("rst_mid_ready", spikes_ready_o, 1);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_pkt", pkt_o, 0);
`ifdef SPIKE_COUNT_EN
        check("rst_mid_count", spike_count_o, 0);
`endif
        exp_q.delete();
        repeat (3) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        sent_cnt = 0;
        load_vec(tbl[1].vec, tbl[1].dx, tbl[1].dy);
        wait_frame(0, d, b);
        check("after_rst_done_cycle", d, 260);
        check("after_rst_busy_cycles", b, 260);
        check("after_rst_sent", sent_cnt, 3);
        check("after_rst_pkts_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
